// File: rtl/serial_sequence_generator.sv
// Serial pattern transmitter: captures {data,len,rep} on a valid/ready transfer and shifts it out MSB-first, with an optional idle gap between repetitions.
// First bit appears the cycle after the transfer; pat_ready is held low from capture until the cycle after the done pulse.
module serial_sequence_generator #(
    parameter int W   = 6,
    parameter int CW  = 4,
    parameter int GAP = 0,
    localparam int LW = $clog2(W + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          pat_valid,
    output logic          pat_ready,
    input  logic [W-1:0]  pat_data,
    input  logic [LW-1:0] pat_len,
    input  logic [CW-1:0] pat_rep,
    output logic          a,
    output logic          a_valid,
    output logic          busy,
    output logic          done
);
    localparam int            GW       = (GAP > 0) ? $clog2(GAP + 1) : 1;
    localparam logic [GW-1:0] GAP_LOAD = (GAP > 0) ? GW'(GAP - 1) : '0;
    localparam logic [LW-1:0] W_MAX    = LW'(W);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP, S_FIN} state_t;

    state_t        r_state;
    state_t        w_next;
    logic [W-1:0]  r_data;
    logic [LW-1:0] r_last;
    logic [LW-1:0] r_idx;
    logic [CW-1:0] r_rep;
    logic [GW-1:0] r_gap;
    logic [LW-1:0] w_len;
    logic [W-1:0]  w_shifted;
    logic          w_xfer;

    assign w_len     = (pat_len > W_MAX) ? W_MAX : pat_len;
    assign pat_ready = (r_state == S_IDLE);
    assign w_xfer    = pat_valid & pat_ready;
    assign w_shifted = r_data >> r_idx;

    // Outputs decode straight from registered state so reset clears them without a clock edge.
    assign a_valid = (r_state == S_SHIFT);
    assign a       = a_valid & w_shifted[0];
    assign busy    = (r_state != S_IDLE);
    assign done    = (r_state == S_FIN);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_xfer) begin
                    w_next = (w_len == '0) ? S_FIN : S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (r_idx == '0) begin
                    if (r_rep == '0) begin
                        w_next = S_FIN;
                    end else if (GAP > 0) begin
                        w_next = S_GAP;
                    end
                end
            end
            S_GAP: begin
                if (r_gap == '0) begin
                    w_next = S_SHIFT;
                end
            end
            S_FIN:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_data <= '0;
            r_last <= '0;
            r_idx  <= '0;
            r_rep  <= '0;
            r_gap  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_xfer) begin
                        r_data <= pat_data;
                        r_last <= (w_len == '0) ? '0 : w_len - LW'(1);
                        r_idx  <= (w_len == '0) ? '0 : w_len - LW'(1);
                        r_rep  <= pat_rep;
                        r_gap  <= GAP_LOAD;
                    end
                end
                S_SHIFT: begin
                    if (r_idx != '0) begin
                        r_idx <= r_idx - LW'(1);
                    end else if (r_rep != '0) begin
                        r_rep <= r_rep - CW'(1);
                        r_idx <= r_last;
                        r_gap <= GAP_LOAD;
                    end
                end
                S_GAP: begin
                    if (r_gap != '0) begin
                        r_gap <= r_gap - GW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_sequence_generator.sv
// Bench for serial_sequence_generator (W=6, CW=4, GAP=2): a per-cycle expected-output queue built from each captured pattern.
module tb_serial_sequence_generator;
    localparam int W   = 6;
    localparam int CW  = 4;
    localparam int GAP = 2;
    localparam int LW  = $clog2(W + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          pat_valid = 1'b0;
    logic          pat_ready;
    logic [W-1:0]  pat_data = '0;
    logic [LW-1:0] pat_len = '0;
    logic [CW-1:0] pat_rep = '0;
    logic          a;
    logic          a_valid;
    logic          busy;
    logic          done;

    serial_sequence_generator #(.W(W), .CW(CW), .GAP(GAP)) dut (
        .clk       (clk),
        .rst       (rst),
        .pat_valid (pat_valid),
        .pat_ready (pat_ready),
        .pat_data  (pat_data),
        .pat_len   (pat_len),
        .pat_rep   (pat_rep),
        .a         (a),
        .a_valid   (a_valid),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    typedef struct packed {
        logic v;
        logic a;
        logic b;
        logic d;
    } exp_t;

    exp_t q[$];
    bit   cur_idle  = 1'b1;
    int   xfer_cnt  = 0;
    int   exp_busy  = 0;
    int   busy_run  = 0;

    // Reference: on each accepted pattern, list every output cycle it should produce.
    always @(posedge clk) begin
        if (rst && cur_idle && pat_valid) begin
            int L;
            int R;
            exp_t e;
            L = (int'(pat_len) > W) ? W : int'(pat_len);
            R = int'(pat_rep);
            if (L > 0) begin
                for (int r = 0; r <= R; r++) begin
                    for (int i = L - 1; i >= 0; i--) begin
                        e = '{v: 1'b1, a: pat_data[i], b: 1'b1, d: 1'b0};
                        q.push_back(e);
                    end
                    if (r < R) begin
                        for (int g = 0; g < GAP; g++) begin
                            e = '{v: 1'b0, a: 1'b0, b: 1'b1, d: 1'b0};
                            q.push_back(e);
                        end
                    end
                end
                exp_busy = L * (R + 1) + GAP * R + 1;
            end else begin
                exp_busy = 1;
            end
            e = '{v: 1'b0, a: 1'b0, b: 1'b1, d: 1'b1};
            q.push_back(e);
            xfer_cnt++;
        end
    end

    always @(negedge rst) begin
        q.delete();
        cur_idle = 1'b1;
        busy_run = 0;
    end

    always @(negedge clk) begin
        exp_t e;
        bit   idle;
        if (q.size() > 0) begin
            e    = q.pop_front();
            idle = 1'b0;
        end else begin
            e    = '0;
            idle = 1'b1;
        end
        cur_idle = idle;
        chk("a_valid", a_valid, e.v);
        chk("a", a, e.a);
        chk("busy", busy, e.b);
        chk("done", done, e.d);
        chk("pat_ready", pat_ready, idle);
        if (busy) busy_run++;
        if (done) chk("busy_len", busy_run, exp_busy);
        if (!busy) busy_run = 0;
    end

    task automatic send(input logic [W-1:0] d, input logic [LW-1:0] l, input logic [CW-1:0] r);
        int start;
        int n;
        start     = xfer_cnt;
        n         = 0;
        pat_valid = 1'b1;
        pat_data  = d;
        pat_len   = l;
        pat_rep   = r;
        while (xfer_cnt == start && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("xfer_wait", (n < 300), 1);
        pat_valid = 1'b0;
    endtask

    initial begin
        #1;
        chk("rst_a", a, 0);
        chk("rst_a_valid", a_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pat_ready", pat_ready, 1);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Second send is held valid while the first is still transmitting.
        send(6'b110011, 3'd6, 4'd0);
        send(6'b001010, 3'd4, 4'd2);
        send(6'b111111, 3'd0, 4'd0);
        send(6'b100001, 3'd7, 4'd0);
        send(6'b101101, 3'd0, 4'd3);
        send(6'b011110, 3'd1, 4'd1);

        // Asynchronous reset during the third bit of 110011.
        send(6'b110011, 3'd6, 4'd0);
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("arst_a", a, 0);
        chk("arst_a_valid", a_valid, 0);
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        chk("arst_pat_ready", pat_ready, 1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (10) @(negedge clk);

        for (int k = 0; k < 40; k++) begin
            int idle_cyc;
            idle_cyc = $urandom_range(0, 3);
            for (int j = 0; j < idle_cyc; j++) begin
                pat_data = W'($urandom);
                pat_len  = LW'($urandom);
                pat_rep  = CW'($urandom);
                @(negedge clk);
            end
            send(W'($urandom), LW'($urandom_range(0, 7)), CW'($urandom_range(0, 3)));
        end

        begin
            int n;
            n = 0;
            while (q.size() > 0 && n < 300) begin
                @(negedge clk);
                n++;
            end
            chk("drain", (n < 300), 1);
        end
        repeat (4) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/serial_sequence_generator.md
# serial_sequence_generator

Serial bit-pattern transmitter: accepts a pattern word (up to W bits, length, repeat count) through a valid/ready handshake and shifts it out MSB-first, one bit per clock, with an optional idle gap between repetitions. It is the transmit end for the FSM sequence detectors: its `a` / `a_valid` output drives their single-bit `a` input. Benches use it as a stimulus source, and designs use it as a framed-pattern emitter.

## Interface
- `W`, default 6: maximum pattern width in bits.
- `CW`, default 4: repeat-count width.
- `GAP`, default 0: idle cycles inserted between consecutive repetitions (0 = back-to-back).
- `LW` (derived, not overridable): `$clog2(W+1)`, the pattern-length field width.

Ports:
- `clk`, input, 1: single clock; all state changes on its rising edge.
- `rst`, input, 1: asynchronous, active-low reset (0 = reset).
- `pat_valid`, input, 1: source offers a pattern.
- `pat_ready`, output, 1: block can accept a pattern.
- `pat_data`, input, W: pattern; `pat_data[len-1]` is sent first, `pat_data[0]` last.
- `pat_len`, input, LW: number of bits to send, 0..W.
- `pat_rep`, input, CW: extra repetitions; the pattern is sent `pat_rep+1` times.
- `a`, output, 1: serial data bit; 0 whenever `a_valid` = 0.
- `a_valid`, output, 1: `a` carries a pattern bit this cycle.
- `busy`, output, 1: a pattern is captured and not yet finished.
- `done`, output, 1: one-cycle pulse after the final bit of the final repetition.

## Operation
- **FSM states:** IDLE, SHIFT, GAP, FIN.
- **Handshake:** a transfer occurs on a rising edge with `pat_valid` & `pat_ready`.
  - `pat_ready` = (state == IDLE), combinational from state.
  - The source holds `pat_data`, `pat_len` and `pat_rep` stable until the transfer.
- **IDLE:**
  - On transfer, capture data, length and repeat count into registers.
  - Load the bit index with `len-1` and the repeat counter with `pat_rep`.
  - Go to SHIFT. If the effective length is 0, go to FIN instead.
- **Length clamp:** `pat_len` > W is clamped to W at capture.
- **SHIFT:**
  - Registered `a` = `data[idx]`, `a_valid` = 1. The index decrements each cycle.
  - At idx 0 with the repeat counter 0, go to FIN.
  - At idx 0 with the repeat counter nonzero: decrement the repeat counter and reload idx with `len-1`. Go to GAP if GAP > 0, else stay in SHIFT.
- **GAP:** `a` = 0, `a_valid` = 0 for exactly GAP cycles, then SHIFT. GAP is never inserted after the last repetition.
- **FIN:**
  - `done` = 1 and `a_valid` = 0 for one cycle, then IDLE.
  - `busy` = 1 in SHIFT, GAP and FIN.
- **While not IDLE:** `pat_valid` is ignored and inputs are not sampled.
- **Reset:**
  - Asserting `rst` at any time (including mid-SHIFT or mid-GAP) clears immediately, without a clock edge.
  - State becomes IDLE and all outputs return to reset values. The captured pattern is discarded; no residual bits appear after release.
- **Counter widths:**
  - idx is LW bits, the repeat counter is CW bits, the gap counter is `$clog2(GAP+1)` bits (minimum 1).
  - No counter wraps: each is tested for 0 before decrementing.

## Timing
- **Reset values:** `a` = 0, `a_valid` = 0, `busy` = 0, `done` = 0, `pat_ready` = 1.
- **Latency:** transfer on edge k puts the first bit on `a` during cycle k+1 (valid after edge k).
- **Single repetition:** `a_valid` is high for `len` consecutive cycles.
- **Repetitions:** each repetition after the first starts GAP cycles after the previous last bit.
- **Total duration:** `busy` is high for `L*(R+1) + GAP*R + 1` cycles, where L = effective length and R = `pat_rep`. The final cycle is FIN, with `done` = 1.
- **Next transfer:** `pat_ready` rises in the cycle after FIN. The earliest next transfer is one cycle after `done`, so there is a minimum one-cycle bubble between patterns.
- **Zero length:** `pat_len` = 0 gives transfer on edge k, FIN (`done` = 1) in cycle k+1, and `a_valid` never asserts.

## Test plan
- **Basic pattern:** reset, then transfer `pat_data` = 6'b110011, `pat_len` = 6, `pat_rep` = 0.
  - Expect `a` = 1,1,0,0,1,1 with `a_valid` = 1 on cycles k+1..k+6, then `done` = 1 on k+7 and `pat_ready` = 1 on k+8.
  - Chained into `detect_6_bit_sequence_using_fsm`, expect `detected` = 1 one cycle after the last bit.
- **Repeats with gap:** GAP = 2, `pat_data` = 4'b1010 (W = 6, `pat_len` = 4), `pat_rep` = 2.
  - Expect three copies of 1,0,1,0, each separated by 2 cycles with `a_valid` = 0 and `a` = 0.
  - `busy` lasts 17 cycles; `done` is on cycle k+17.
- **Length boundaries:** `pat_len` = 0 gives `done` on k+1 and no `a_valid`. `pat_len` = 7 with W = 6 and `pat_data` = 6'b100001 gives exactly 6 bits: 1,0,0,0,0,1.
- **Busy-period input:** hold `pat_valid` = 1 with new data during transmission.
  - Expect `pat_ready` = 0 throughout; the new data is not sampled.
  - The second transfer occurs the cycle after `done`, and its first bit appears one cycle later.
- **Reset mid-operation:** drive `rst` = 0 asynchronously during bit 3 of 110011.
  - Expect `a`, `a_valid`, `busy` and `done` = 0 before the next clock edge.
  - After release, expect `pat_ready` = 1 and no further `a_valid` until a new transfer.
